// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundle between the multicycle control FSM and its datapath.
//   master : the control unit (consumes IR fields/flags, drives enables/muxes)
//   slave  : the datapath (drives IR fields/flags, consumes enables/muxes)
//   Inputs to control : op, funct3, funct7b5, zero, mem_ready
//   Outputs of control: PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
//                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU_control,
//                       instr_done, illegal, fsm_state
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALU_control;
    logic       instr_done;
    logic       illegal;
    logic [3:0] fsm_state;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALU_control, instr_done, illegal,
               fsm_state
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALU_control, instr_done, illegal,
               fsm_state
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore FSM sequencing RV32I instructions (lw, sw, R-type, I-type ALU,
//   beq/optional bne, jal) through a shared ALU and unified memory.
//   Stalls on mem_ready in FETCH, MEMREAD and MEMWRITE; unsupported opcodes
//   (or bne when EXT_BRANCH=0) park the FSM in TRAP until reset.
//   Parameters:
//     MEM_WAIT   1 = honour mem_ready, 0 = memory always ready
//     EXT_BRANCH 1 = bne (funct3 001) is legal
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    control/datapath bundle (master side)
module multicycle_control #(
    parameter bit MEM_WAIT   = 1'b1,
    parameter bit EXT_BRANCH = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    // State-only (Moore) part of the control word.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALU operation for EXECR/EXECI. Only R-type (op[5]=1) may subtract.
    function automatic logic [2:0] funct_alu(input logic op5, input logic [2:0] f3,
                                             input logic f7b5);
        logic [2:0] a;
        case (f3)
            3'b000:  a = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  a = ALU_SLT;
            3'b110:  a = ALU_OR;
            3'b111:  a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic ctrl_t moore_outs(input state_e s, input logic [2:0] alu_dec);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a   = SRCA_PC;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
                c.result_src  = RES_ALURES;
            end
            S_DECODE: begin
                c.alu_src_a   = SRCA_OLDPC;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole state, i.e. until mem_ready.
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = alu_dec;
            end
            S_EXECI: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = alu_dec;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = ALU_SUB;
                c.result_src  = RES_ALUOUT;
                c.instr_done  = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a   = SRCA_OLDPC;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
                c.result_src  = RES_ALUOUT;
                c.pc_write    = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       ready;
    logic       branch_legal;
    logic       branch_taken;
    logic [1:0] imm_src;

    always_comb begin
        ready        = MEM_WAIT ? bus.mem_ready : 1'b1;
        branch_legal = (bus.funct3 == 3'b000) | (EXT_BRANCH & (bus.funct3 == 3'b001));
        branch_taken = ((bus.funct3 == 3'b000) & bus.zero) |
                       (EXT_BRANCH & (bus.funct3 == 3'b001) & ~bus.zero);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = branch_legal ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // The Moore control word is decoded one cycle early from the next state,
    // so it appears registered yet lines up with state_q. IR fields are stable
    // from DECODE onward, so decoding funct bits here is safe.
    always_comb begin
        ctrl_d = moore_outs(reset ? S_FETCH : state_d,
                            funct_alu(bus.op[5], bus.funct3, bus.funct7b5));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
        ctrl_q <= ctrl_d;
    end

    always_comb begin
        case (bus.op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Mealy overlays: fetch handshake, branch decision, store completion.
    assign bus.PCWrite     = ctrl_q.pc_write |
                             ((state_q == S_FETCH) & ready) |
                             ((state_q == S_BRANCH) & branch_taken);
    assign bus.IRWrite     = ctrl_q.ir_write | ((state_q == S_FETCH) & ready);
    assign bus.instr_done  = ctrl_q.instr_done | ((state_q == S_MEMWRITE) & ready);
    assign bus.AdrSrc      = ctrl_q.adr_src;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.ResultSrc   = ctrl_q.result_src;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALU_control = ctrl_q.alu_control;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.ImmSrc      = imm_src;
    assign bus.fsm_state   = state_q;

endmodule
